// File: rtl/cnn_pkg.sv
// Shared CNN constants: feature-map geometry, pooling FSM states,
// and the 2x2 pooling window offset table.
package cnn_pkg;

  localparam int DATA_W = 32;
  localparam int FMAP_W = 6;
  localparam int FMAP_H = 6;
  localparam int ADDR_W = 6;
  localparam int IDX_W  = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // {dy,dx} per read slot k: (0,0),(0,1),(1,0),(1,1)
  localparam logic [7:0] WIN_OFS = {2'b11, 2'b10, 2'b01, 2'b00};

  function automatic logic [1:0] win_ofs(input logic [1:0] k);
    return WIN_OFS[{k, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/relu_maxpool_unit_if.sv
// Feature-map read port plus pooled output stream.
// master = pooling unit, slave = memory / consumer side.
interface relu_maxpool_unit_if #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int ADDR_W = cnn_pkg::ADDR_W,
  parameter int IDX_W  = cnn_pkg::IDX_W
);
  logic              fm_rd_en;
  logic [ADDR_W-1:0] fm_rd_addr;
  logic [DATA_W-1:0] fm_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;

  modport master (
    output fm_rd_en, fm_rd_addr,
    input  fm_rd_data,
    output out_valid, out_data, out_index,
    input  out_ready
  );

  modport slave (
    input  fm_rd_en, fm_rd_addr,
    output fm_rd_data,
    input  out_valid, out_data, out_index,
    output out_ready
  );
endinterface

// File: rtl/pool_addr_gen.sv
// Window walker: k selects the pixel inside the 2x2 window,
// pr/pc select the window; produces read address and output index.
import cnn_pkg::*;

module pool_addr_gen #(
  parameter int FMAP_W = cnn_pkg::FMAP_W,
  parameter int FMAP_H = cnn_pkg::FMAP_H,
  parameter int ADDR_W = cnn_pkg::ADDR_W,
  parameter int IDX_W  = cnn_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              k_step,
  input  logic              win_step,
  output logic [1:0]        k,
  output logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              win_last
);

  localparam logic [IDX_W-1:0] PC_MAX = IDX_W'(FMAP_W/2 - 1);
  localparam logic [IDX_W-1:0] PR_MAX = IDX_W'(FMAP_H/2 - 1);

  logic [IDX_W-1:0] pr;
  logic [IDX_W-1:0] pc;
  logic [1:0]       ofs;

  assign ofs = win_ofs(k);
  assign win_last = (pr == PR_MAX) && (pc == PC_MAX);
  assign addr = ADDR_W'((2*int'(pr) + int'(ofs[1])) * FMAP_W
                + 2*int'(pc) + int'(ofs[0]));
  assign idx = IDX_W'(int'(pr) * (FMAP_W/2) + int'(pc));

  // slot counter wraps every 4 reads; window counters walk row-major
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      k  <= '0;
      pr <= '0;
      pc <= '0;
    end else begin
      if (k_step)
        k <= k + 2'd1;
      if (win_step) begin
        if (pc == PC_MAX) begin
          pc <= '0;
          pr <= (pr == PR_MAX) ? '0 : pr + 1'b1;
        end else begin
          pc <= pc + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/relu_maxpool_unit.sv
// ReLU + 2x2/stride-2 max-pool over the conv feature map,
// streaming pooled words out on a valid/ready port.
import cnn_pkg::*;

module relu_maxpool_unit #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int FMAP_W = cnn_pkg::FMAP_W,
  parameter int FMAP_H = cnn_pkg::FMAP_H,
  parameter int ADDR_W = cnn_pkg::ADDR_W,
  parameter int IDX_W  = cnn_pkg::IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  relu_maxpool_unit_if.master bus,
  output logic                busy,
  output logic                done
);

  logic [2:0]               state;
  logic signed [DATA_W-1:0] max_q;
  logic signed [DATA_W-1:0] d;
  logic signed [DATA_W-1:0] cand;
  logic [ADDR_W-1:0]        gen_addr;
  logic [ADDR_W-1:0]        addr_hold;
  logic [IDX_W-1:0]         gen_idx;
  logic [1:0]               k;
  logic                     win_last;
  logic                     go;
  logic                     in_read;
  logic                     in_last;
  logic                     hs;
  logic                     cap;
  logic                     first;

  assign go      = start && (state == S_IDLE || state == S_DONE);
  assign in_read = (state == S_READ);
  assign in_last = (state == S_LAST);
  assign hs      = (state == S_EMIT) && bus.out_ready;

  // read k returns during cycle k+1; slot 1 sees the window's first word
  assign cap   = (in_read && k != 2'd0) || in_last;
  assign first = in_read && (k == 2'd1);
  assign d     = bus.fm_rd_data;
  assign cand  = first ? d : ((d > max_q) ? d : max_q);

  assign bus.fm_rd_en   = in_read;
  assign bus.fm_rd_addr = in_read ? gen_addr : addr_hold;

  pool_addr_gen #(
    .FMAP_W (FMAP_W),
    .FMAP_H (FMAP_H),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (go),
    .k_step   (in_read),
    .win_step (hs),
    .k        (k),
    .addr     (gen_addr),
    .idx      (gen_idx),
    .win_last (win_last)
  );

  // pass sequencing, running max and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      max_q         <= '0;
      addr_hold     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_index <= '0;
    end else begin
      if (in_read)
        addr_hold <= gen_addr;
      if (cap)
        max_q <= cand;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_READ;
            busy  <= 1'b1;
          end
        end
        S_READ: begin
          if (k == 2'd3)
            state <= S_LAST;
        end
        S_LAST: begin
          state         <= S_EMIT;
          bus.out_valid <= 1'b1;
          bus.out_data  <= cand[DATA_W-1] ? '0 : cand;
          bus.out_index <= gen_idx;
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (win_last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_READ;
            done  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_maxpool_unit.sv
// Scoreboard bench for relu_maxpool_unit: directed feature maps,
// expected pooled words queued at issue, checked by a monitor.
module tb_relu_maxpool_unit;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  relu_maxpool_unit_if bus ();

  relu_maxpool_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  logic [31:0] fm [36];

  always @(posedge clk)
    if (bus.fm_rd_en)
      bus.fm_rd_data <= fm[bus.fm_rd_addr];

  int n_vec = 0;
  int n_err = 0;
  logic [35:0] sb [$];
  int ramp_exp [9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // monitor: every accepted output pops one expected word
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_out: got idx %0d data %0h required none",
                   bus.out_index, bus.out_data);
        end else begin
          e = sb.pop_front();
          chk("out_index", 32'(bus.out_index), 32'(e[35:32]));
          chk("out_data", bus.out_data, e[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic push_exp(input int idx, input logic [31:0] v);
    sb.push_back({4'(idx), v});
  endtask

  task automatic push_ramp();
    for (int i = 0; i < 9; i++)
      push_exp(i, 32'(ramp_exp[i]));
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 36; i++)
      fm[i] = 32'(i);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("done", 32'(done), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_out(input int idx, output bit ok);
    int t = 0;
    ok = 1'b0;
    while (t < 500 && !ok) begin
      @(negedge clk);
      t++;
      ok = bus.out_valid && (int'(bus.out_index) == idx);
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_out: got timeout required idx %0d", idx);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(bus.fm_rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(bus.fm_rd_addr), 32'd0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_data"}, bus.out_data, 32'd0);
    chk({tag, "_index"}, 32'(bus.out_index), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit ok;
    int t;
    bus.out_ready = 1'b1;
    fill_ramp();
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;

    // ramp pass
    push_ramp();
    pulse_start();
    chk("busy_run", 32'(busy), 32'd1);
    wait_done();

    // restart from DONE, with a stray start mid-pass
    push_ramp();
    pulse_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    repeat (20) @(posedge clk);
    pulse_start();
    wait_done();

    // backpressure on output 3
    push_ramp();
    pulse_start();
    wait_out(2, ok);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_data", bus.out_data, 32'd19);
      chk("bp_index", 32'(bus.out_index), 32'd3);
      chk("bp_rd_en", 32'(bus.fm_rd_en), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_done();

    // reset right after the 4th handshake
    push_ramp();
    pulse_start();
    wait_out(3, ok);
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 chk_zero("midrst");
    rst = 1'b0;
    push_ramp();
    pulse_start();
    wait_done();

    // all negative: ReLU clamps every window
    for (int i = 0; i < 36; i++)
      fm[i] = -32'sd5;
    for (int i = 0; i < 9; i++)
      push_exp(i, 32'd0);
    pulse_start();
    wait_done();

    // signed compare at full width
    for (int i = 0; i < 36; i++)
      fm[i] = 32'd0;
    fm[0] = -32'sd100;
    fm[1] = -32'sd3;
    fm[6] = 32'd2;
    fm[7] = -32'sd7;
    fm[2] = 32'h8000_0000;
    fm[3] = 32'h7FFF_FFFF;
    fm[8] = 32'hFFFF_FFFF;
    fm[9] = 32'd0;
    push_exp(0, 32'd2);
    push_exp(1, 32'h7FFF_FFFF);
    for (int i = 2; i < 9; i++)
      push_exp(i, 32'd0);
    pulse_start();
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
